// File: rtl/mat_vec_engine_if.sv
// mat_vec_engine_if: RAM read port and result stream bundled for the matrix-vector engine.
interface mat_vec_engine_if #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIM       = 4,
  parameter int unsigned ACC_WIDTH = 32
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                 rd_available;
  logic [AW-1:0]        rd_addr;
  logic [31:0]          rd_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic [RW-1:0]        res_row;

  // Engine side
  modport master (
    input  rd_available, rd_data, res_ready,
    output rd_addr, res_valid, res_data, res_row
  );

  // Memory / consumer side
  modport slave (
    output rd_available, rd_data, res_ready,
    input  rd_addr, res_valid, res_data, res_row
  );
endinterface

// File: rtl/mat_vec_engine.sv
// mat_vec_engine: multiplies a row-major DIMxDIM matrix read from RAM by a latched vector and
// streams one dot product per row over a valid/ready handshake.
// Optional MATVEC_SATURATE_EN: saturating accumulate and a sticky o_sat_flag output.
module mat_vec_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DIM        = 4,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [DIM*DATA_WIDTH-1:0] i_vec_in,
  mat_vec_engine_if.master          io_bus,
  output logic                      o_busy,
  output logic                      o_done
`ifdef MATVEC_SATURATE_EN
  ,
  output logic                      o_sat_flag
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned PW = 32 + DATA_WIDTH;
  localparam int unsigned SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
  localparam logic [RW-1:0] LastIdx = RW'(DIM - 1);

  if (DIM * DIM > DEPTH) begin : g_dim_check
    $error("mat_vec_engine: DIM*DIM exceeds DEPTH");
  end

  typedef enum logic [2:0] {StIdle, StWaitMem, StFetch, StDrain, StOutput, StDone} state_e;

  state_e                    r_state, w_state_next;
  logic [DIM*DATA_WIDTH-1:0] r_vec, w_vec_next;
  logic [ACC_WIDTH-1:0]      r_acc, w_acc_next, w_acc_upd;
  logic [RW-1:0]             r_row, w_row_next;
  logic [RW-1:0]             r_col, w_col_next;
  logic [RW-1:0]             r_col_d1, w_col_d1_next;
  logic                      r_vld_d1, w_vld_d1_next;
  logic [AW-1:0]             r_addr, w_addr_next;

  logic [DATA_WIDTH-1:0]     w_elem;
  logic [PW-1:0]             w_a, w_b, w_prod;
  logic signed [SW-1:0]      w_prod_ext, w_acc_ext, w_sum;

  // Operands are sign-extended to the product width so the low PW bits are the signed product.
  assign w_elem     = r_vec[int'(r_col_d1)*DATA_WIDTH +: DATA_WIDTH];
  assign w_a        = {{DATA_WIDTH{io_bus.rd_data[31]}}, io_bus.rd_data};
  assign w_b        = {{32{w_elem[DATA_WIDTH-1]}}, w_elem};
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(SW-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_ext  = {{(SW-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
  assign w_sum      = w_acc_ext + w_prod_ext;

`ifdef MATVEC_SATURATE_EN
  logic                 r_sat, w_sat_next, w_clamp;
  logic signed [SW-1:0] w_sat_max, w_sat_min;
  assign w_sat_max = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  assign w_sat_min = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  // Clamp the exact sum to the accumulator range.
  always_comb begin
    w_clamp   = 1'b0;
    w_acc_upd = w_sum[ACC_WIDTH-1:0];
    if (w_sum > w_sat_max) begin
      w_acc_upd = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      w_clamp   = 1'b1;
    end else if (w_sum < w_sat_min) begin
      w_acc_upd = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      w_clamp   = 1'b1;
    end
  end
  assign o_sat_flag = r_sat;
`else
  logic w_unused_sum_hi;
  assign w_unused_sum_hi = ^w_sum[SW-1:ACC_WIDTH];
  // Plain two's-complement wrap.
  always_comb begin
    w_acc_upd = w_sum[ACC_WIDTH-1:0];
  end
`endif

  // Next-state logic; the accumulate runs one cycle behind the address it belongs to.
  always_comb begin
    w_state_next  = r_state;
    w_vec_next    = r_vec;
    w_acc_next    = r_acc;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_col_d1_next = r_col;
    w_vld_d1_next = 1'b0;
    w_addr_next   = r_addr;
`ifdef MATVEC_SATURATE_EN
    w_sat_next    = r_sat;
`endif
    if (r_vld_d1) begin
      w_acc_next = w_acc_upd;
`ifdef MATVEC_SATURATE_EN
      w_sat_next = r_sat | w_clamp;
`endif
    end
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_vec_next   = i_vec_in;
          w_acc_next   = '0;
          w_row_next   = '0;
          w_col_next   = '0;
          w_addr_next  = '0;
`ifdef MATVEC_SATURATE_EN
          w_sat_next   = 1'b0;
`endif
          w_state_next = StWaitMem;
        end
      end
      StWaitMem: begin
        if (io_bus.rd_available) begin
          w_col_next   = '0;
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        w_vld_d1_next = 1'b1;
        if (r_col == LastIdx) begin
          w_state_next = StDrain;
        end else begin
          w_col_next  = r_col + RW'(1);
          w_addr_next = r_addr + AW'(1);
        end
      end
      StDrain: w_state_next = StOutput;
      StOutput: begin
        if (io_bus.res_ready) begin
          if (r_row == LastIdx) begin
            w_state_next = StDone;
          end else begin
            w_row_next   = r_row + RW'(1);
            w_acc_next   = '0;
            w_col_next   = '0;
            w_addr_next  = r_addr + AW'(1);
            w_state_next = StFetch;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= StIdle;
      r_vec    <= '0;
      r_acc    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_col_d1 <= '0;
      r_vld_d1 <= 1'b0;
      r_addr   <= '0;
`ifdef MATVEC_SATURATE_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_vec    <= w_vec_next;
      r_acc    <= w_acc_next;
      r_row    <= w_row_next;
      r_col    <= w_col_next;
      r_col_d1 <= w_col_d1_next;
      r_vld_d1 <= w_vld_d1_next;
      r_addr   <= w_addr_next;
`ifdef MATVEC_SATURATE_EN
      r_sat    <= w_sat_next;
`endif
    end
  end

  assign io_bus.rd_addr   = r_addr;
  assign io_bus.res_valid = (r_state == StOutput);
  assign io_bus.res_data  = r_acc;
  assign io_bus.res_row   = r_row;
  assign o_busy           = (r_state != StIdle) && (r_state != StDone);
  assign o_done           = (r_state == StDone);

endmodule

// File: tb/tb_mat_vec_engine.sv
// tb_mat_vec_engine: scoreboard bench; stimulus pushes expected rows, negedge monitors check them.
module tb_mat_vec_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start16;
  logic [31:0] vec, vec16;
  logic        busy, done, busy16, done16;
`ifdef MATVEC_SATURATE_EN
  logic        sat, sat16;
`endif

  mat_vec_engine_if #(.DEPTH(16), .DIM(4), .ACC_WIDTH(32)) bus ();
  mat_vec_engine_if #(.DEPTH(16), .DIM(4), .ACC_WIDTH(16)) bus16 ();

  mat_vec_engine #(.DATA_WIDTH(8), .DEPTH(16), .DIM(4), .ACC_WIDTH(32)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_vec_in(vec), .io_bus(bus),
    .o_busy(busy), .o_done(done)
`ifdef MATVEC_SATURATE_EN
    , .o_sat_flag(sat)
`endif
  );

  mat_vec_engine #(.DATA_WIDTH(8), .DEPTH(16), .DIM(4), .ACC_WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start16), .i_vec_in(vec16), .io_bus(bus16),
    .o_busy(busy16), .o_done(done16)
`ifdef MATVEC_SATURATE_EN
    , .o_sat_flag(sat16)
`endif
  );

  logic [31:0] mem   [16];
  logic [31:0] mem16 [16];
  always @(posedge clk) bus.rd_data   <= mem[bus.rd_addr];
  always @(posedge clk) bus16.rd_data <= mem16[bus16.rd_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_data_q[$];
  int exp_row_q[$];
  int exp16_q[$];
  int xfer_cyc[$];
  int e_d, e_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Main DUT monitor
  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      if (exp_data_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_result: got data=%0d row=%0d, none expected",
                 $signed(bus.res_data), bus.res_row);
      end else begin
        e_d = exp_data_q.pop_front();
        e_r = exp_row_q.pop_front();
        chk("res_data", bus.res_data, 32'(e_d));
        chk("res_row", 32'(bus.res_row), 32'(e_r));
`ifdef MATVEC_SATURATE_EN
        chk("sat_flag", 32'(sat), 32'd0);
`endif
        xfer_cyc.push_back(cyc);
      end
    end
  end

  // 16-bit accumulator DUT monitor
  always @(negedge clk) begin
    if (bus16.res_valid && bus16.res_ready) begin
      if (exp16_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_result16: got data=0x%0h, none expected", bus16.res_data);
      end else begin
        chk("res16_data", 32'(bus16.res_data), 32'(exp16_q.pop_front()));
`ifdef MATVEC_SATURATE_EN
        chk("sat16_flag", 32'(sat16), 32'd1);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int d0, input int d1, input int d2, input int d3);
    exp_data_q.push_back(d0); exp_row_q.push_back(0);
    exp_data_q.push_back(d1); exp_row_q.push_back(1);
    exp_data_q.push_back(d2); exp_row_q.push_back(2);
    exp_data_q.push_back(d3); exp_row_q.push_back(3);
  endtask

  task automatic pulse_start(input logic [31:0] v);
    vec   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int n = 0; n < budget && !done; n++) @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_drained"}, 32'(exp_data_q.size()), 32'd0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({name, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({name, "_res_data"}, bus.res_data, 32'd0);
    chk({name, "_res_row"}, 32'(bus.res_row), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 32'((i + 1) % 16);
      mem16[i] = 32'h0000_7FFF;
    end
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0;
    vec = '0; vec16 = '0;
    bus.rd_available = 1'b1;   bus.res_ready = 1'b1;
    bus16.rd_available = 1'b1; bus16.res_ready = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    // 16-bit accumulator overflow: 4 * 32767 * 127 per row
`ifdef MATVEC_SATURATE_EN
    for (int i = 0; i < 4; i++) exp16_q.push_back(32'h7FFF);
`else
    for (int i = 0; i < 4; i++) exp16_q.push_back(32'hFE04);
`endif
    vec16 = 32'h7F7F_7F7F;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (n = 0; n < 100 && !done16; n++) @(negedge clk);
    chk("acc16_done", 32'(done16), 32'd1);
    chk("acc16_drained", 32'(exp16_q.size()), 32'd0);
    tick();

    // All-ones vector: row sums and 6-cycle row spacing
    xfer_cyc.delete();
    push4(10, 26, 42, 42);
    pulse_start(32'h0101_0101);
    wait_done("ones", 100);
    chk("ones_nxfer", 32'(xfer_cyc.size()), 32'd4);
    for (int i = 1; i < 4 && i < xfer_cyc.size(); i++)
      chk("row_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd6);

    // Restart from DONE with column selectors
    push4(1, 5, 9, 13);
    pulse_start(32'h0000_0001);
    wait_done("e0", 100);
    push4(7, 11, 15, -13);
    pulse_start(32'h0200_00FF);
    wait_done("neg", 100);

    // Back-pressure on row 1
    push4(10, 26, 42, 42);
    pulse_start(32'h0101_0101);
    for (n = 0; n < 50 && !(bus.res_valid && bus.res_row == 2'd0); n++) @(negedge clk);
    tick();
    bus.res_ready = 1'b0;
    for (n = 0; n < 50 && !bus.res_valid; n++) @(negedge clk);
    chk("bp_valid", 32'(bus.res_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", bus.res_data, 32'd26);
      chk("bp_row", 32'(bus.res_row), 32'd1);
      chk("bp_addr", 32'(bus.rd_addr), 32'd7);
    end
    tick();
    bus.res_ready = 1'b1;
    wait_done("bp", 100);

    // Memory not yet available
    bus.rd_available = 1'b0;
    push4(1, 5, 9, 13);
    pulse_start(32'h0000_0001);
    repeat (8) begin
      @(negedge clk);
      chk("wm_addr", 32'(bus.rd_addr), 32'd0);
      chk("wm_valid", 32'(bus.res_valid), 32'd0);
      chk("wm_busy", 32'(busy), 32'd1);
    end
    tick();
    bus.rd_available = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.res_valid) break;
    end
    chk("wm_latency", 32'(n), 32'd6);
    wait_done("wm", 100);

    // Start during FETCH of row 2 is ignored
    push4(10, 26, 42, 42);
    pulse_start(32'h0101_0101);
    for (n = 0; n < 60 && bus.rd_addr != 4'd9; n++) @(negedge clk);
    chk("ign_at_row2", 32'(bus.rd_addr), 32'd9);
    tick();
    pulse_start(32'h0202_0202);
    chk("ign_busy", 32'(busy), 32'd1);
    wait_done("ign", 100);

    // Reset mid row 1 aborts immediately
    push4(10, 26, 42, 42);
    pulse_start(32'h0101_0101);
    for (n = 0; n < 60 && bus.rd_addr != 4'd5; n++) @(negedge clk);
    chk("rst_at_row1", 32'(bus.rd_addr), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    exp_data_q.delete();
    exp_row_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    push4(7, 11, 15, -13);
    pulse_start(32'h0200_00FF);
    wait_done("post_rst", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
